// File: rtl/usc_rv_pkg.sv
// Shared types and helpers for the instruction buffer: the fetch-info field map,
// the stored entry layout and a leading-ones counter used for enqueue and
// dequeue widths.
`ifndef USC_RV_FETCH_INFO_W
`define USC_RV_FETCH_INFO_PRED 0
`define USC_RV_FETCH_INFO_AF   1
`define USC_RV_FETCH_INFO_PF   2
`define USC_RV_FETCH_INFO_W    3
`endif

package usc_rv_pkg;

  localparam int FETCH_INFO_W    = `USC_RV_FETCH_INFO_W;
  localparam int FETCH_INFO_PRED = `USC_RV_FETCH_INFO_PRED;
  localparam int FETCH_INFO_AF   = `USC_RV_FETCH_INFO_AF;
  localparam int FETCH_INFO_PF   = `USC_RV_FETCH_INFO_PF;

  // One queue entry: opcode, its own PC and the packet info it arrived with.
  typedef struct packed {
    logic [31:0]             opc;
    logic [31:0]             pc;
    logic [FETCH_INFO_W-1:0] info;
  } ibuf_entry_t;

  // Number of consecutive ones starting at bit 0. Stops at the first zero, so
  // a non-prefix valid/take vector only contributes its leading run.
  function automatic logic [2:0] lead_ones(input logic [3:0] v);
    logic [2:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run = run & v[i];
      n   = n + {2'b00, run};
    end
    return n;
  endfunction

endpackage

// File: rtl/usc_rv_ibuf_ptr.sv
// Read/write pointer and occupancy counter for the instruction queue.
// Pointers carry one wrap bit above the index; only the index leaves the block.
// Flush returns everything to zero and overrides any enqueue/dequeue that cycle.
module usc_rv_ibuf_ptr #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic [CW-1:0] n_enq_i,
  input  logic [CW-1:0] n_deq_i,
  output logic [AW-1:0] rd_idx_o,
  output logic [AW-1:0] wr_idx_o,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] rd_q, rd_d;
  logic [CW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: flush clears, otherwise advance by accepted/consumed amounts.
  always_comb begin
    rd_d  = rd_q + n_deq_i;
    wr_d  = wr_q + n_enq_i;
    cnt_d = cnt_q + n_enq_i - n_deq_i;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_idx_o = rd_q[AW-1:0];
  assign wr_idx_o = wr_q[AW-1:0];
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/usc_rv_ibuf.sv
// In-order instruction queue between fetch F2 and the decode lanes.
// Enqueued entries are visible to decode one cycle later; no bypass.
// Fetch is stalled whole-packet when fewer than FETCH_W entries are free.
module usc_rv_ibuf
  import usc_rv_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int DEPTH   = 8,
  parameter int INFO_W  = FETCH_INFO_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FETCH_W-1:0]            inst_vld_f2,
  output logic                          inst_rdy_f2,
  input  logic [FETCH_W-1:0][31:0]      inst_data_f2,
  input  logic [INFO_W-1:0]             inst_info_f2,
  input  logic [31:0]                   inst_pc_f2,
  input  logic                          core_flush,
  output logic [DEC_W-1:0]              dec_vld_o,
  output logic [DEC_W-1:0][31:0]        dec_opc_o,
  output logic [DEC_W-1:0][31:0]        dec_pc_o,
  output logic [DEC_W-1:0][INFO_W-1:0]  dec_info_o,
  input  logic [DEC_W-1:0]              dec_take_i,
  output logic [CW-1:0]                 ibuf_cnt_o
);

  logic [AW-1:0] rd_idx, wr_idx;
  logic [CW-1:0] cnt, free_cnt, n_enq, n_deq;
  logic [DEC_W-1:0] take_eff;

  // Payload storage; deliberately not reset, validity comes from the counter.
  ibuf_entry_t mem_q [DEPTH];

  usc_rv_ibuf_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (core_flush),
    .n_enq_i  (n_enq),
    .n_deq_i  (n_deq),
    .rd_idx_o (rd_idx),
    .wr_idx_o (wr_idx),
    .cnt_o    (cnt)
  );

  // Ready looks only at the registered count: a dequeue this cycle does not
  // free space for this cycle's packet, keeping the ready path short.
  assign free_cnt    = CW'(DEPTH) - cnt;
  assign inst_rdy_f2 = ~core_flush & (free_cnt >= CW'(FETCH_W));
  assign n_enq       = inst_rdy_f2 ? CW'(lead_ones(4'(inst_vld_f2))) : '0;

  assign take_eff    = dec_take_i & dec_vld_o;
  assign n_deq       = CW'(lead_ones(4'(take_eff)));
  assign ibuf_cnt_o  = cnt;

  // Write the leading valid slots of an accepted packet at consecutive entries.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (CW'(k) < n_enq) begin
        mem_q[wr_idx + AW'(k)] <= '{opc:  inst_data_f2[k],
                                    pc:   inst_pc_f2 + 32'(4 * k),
                                    info: FETCH_INFO_W'(inst_info_f2)};
      end
    end
  end

  // Present the DEC_W oldest entries; lane k is valid while count exceeds k.
  always_comb begin
    dec_vld_o  = '0;
    dec_opc_o  = '0;
    dec_pc_o   = '0;
    dec_info_o = '0;
    for (int k = 0; k < DEC_W; k++) begin
      dec_vld_o[k]  = (cnt > CW'(k));
      dec_opc_o[k]  = mem_q[rd_idx + AW'(k)].opc;
      dec_pc_o[k]   = mem_q[rd_idx + AW'(k)].pc;
      dec_info_o[k] = INFO_W'(mem_q[rd_idx + AW'(k)].info);
    end
  end

endmodule

// File: tb/tb_usc_rv_ibuf.sv
// Directed bench for usc_rv_ibuf with FETCH_W=2, DEC_W=2, DEPTH=8: a vector
// table for single-cycle behaviour plus sequences for wrap, fault info,
// flush-when-full and asynchronous reset.
module tb_usc_rv_ibuf;
  import usc_rv_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [1:0]                  inst_vld_f2 = '0;
  logic                        inst_rdy_f2;
  logic [1:0][31:0]            inst_data_f2 = '0;
  logic [FETCH_INFO_W-1:0]     inst_info_f2 = '0;
  logic [31:0]                 inst_pc_f2 = '0;
  logic                        core_flush = 1'b0;
  logic [1:0]                  dec_vld_o;
  logic [1:0][31:0]            dec_opc_o;
  logic [1:0][31:0]            dec_pc_o;
  logic [1:0][FETCH_INFO_W-1:0] dec_info_o;
  logic [1:0]                  dec_take_i = '0;
  logic [3:0]                  ibuf_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  usc_rv_ibuf #(.FETCH_W(2), .DEC_W(2), .DEPTH(8), .INFO_W(FETCH_INFO_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_vld_f2  (inst_vld_f2),
    .inst_rdy_f2  (inst_rdy_f2),
    .inst_data_f2 (inst_data_f2),
    .inst_info_f2 (inst_info_f2),
    .inst_pc_f2   (inst_pc_f2),
    .core_flush   (core_flush),
    .dec_vld_o    (dec_vld_o),
    .dec_opc_o    (dec_opc_o),
    .dec_pc_o     (dec_pc_o),
    .dec_info_o   (dec_info_o),
    .dec_take_i   (dec_take_i),
    .ibuf_cnt_o   (ibuf_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  take;
    logic        flush;
    logic [31:0] pc;
    logic        rdy;
    logic [3:0]  cnt;
    logic [1:0]  dvld;
    logic [31:0] pc0;
    logic [31:0] pc1;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [31:0] opc_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] t, input logic f,
                       input logic [31:0] pc, input logic [FETCH_INFO_W-1:0] info);
    inst_vld_f2  = v;
    dec_take_i   = t;
    core_flush   = f;
    inst_pc_f2   = pc;
    inst_info_f2 = info;
    for (int k = 0; k < 2; k++) inst_data_f2[k] = opc_of(pc + 32'(4 * k));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int next_in;
    int next_out;
    int cyc;
    logic acc;
    logic [FETCH_INFO_W-1:0] pf;
    pf = '0;
    pf[FETCH_INFO_PF] = 1'b1;

    //          vld    take   fl    pc          rdy   cnt   dvld   pc0         pc1
    tbl[0]  = '{2'b11, 2'b00, 1'b0, 32'h1000, 1'b1, 4'd2, 2'b11, 32'h1000, 32'h1004};
    tbl[1]  = '{2'b11, 2'b00, 1'b0, 32'h1008, 1'b1, 4'd4, 2'b11, 32'h1000, 32'h1004};
    tbl[2]  = '{2'b11, 2'b00, 1'b0, 32'h1010, 1'b1, 4'd6, 2'b11, 32'h1000, 32'h1004};
    tbl[3]  = '{2'b11, 2'b00, 1'b0, 32'h1018, 1'b1, 4'd8, 2'b11, 32'h1000, 32'h1004};
    tbl[4]  = '{2'b11, 2'b00, 1'b0, 32'h1020, 1'b0, 4'd8, 2'b11, 32'h1000, 32'h1004};
    tbl[5]  = '{2'b11, 2'b01, 1'b0, 32'h1020, 1'b0, 4'd7, 2'b11, 32'h1004, 32'h1008};
    tbl[6]  = '{2'b11, 2'b00, 1'b0, 32'h1020, 1'b0, 4'd7, 2'b11, 32'h1004, 32'h1008};
    tbl[7]  = '{2'b11, 2'b11, 1'b0, 32'h1020, 1'b0, 4'd5, 2'b11, 32'h100C, 32'h1010};
    tbl[8]  = '{2'b11, 2'b00, 1'b0, 32'h1020, 1'b1, 4'd7, 2'b11, 32'h100C, 32'h1010};
    tbl[9]  = '{2'b00, 2'b11, 1'b0, 32'h0000, 1'b0, 4'd5, 2'b11, 32'h1014, 32'h1018};
    tbl[10] = '{2'b00, 2'b11, 1'b0, 32'h0000, 1'b1, 4'd3, 2'b11, 32'h101C, 32'h1020};
    tbl[11] = '{2'b01, 2'b01, 1'b0, 32'h1028, 1'b1, 4'd3, 2'b11, 32'h1020, 32'h1024};
    tbl[12] = '{2'b00, 2'b10, 1'b0, 32'h0000, 1'b1, 4'd3, 2'b11, 32'h1020, 32'h1024};
    tbl[13] = '{2'b11, 2'b11, 1'b1, 32'h2000, 1'b0, 4'd0, 2'b00, 32'h0000, 32'h0000};
    tbl[14] = '{2'b11, 2'b00, 1'b0, 32'h3000, 1'b1, 4'd2, 2'b11, 32'h3000, 32'h3004};
    tbl[15] = '{2'b10, 2'b00, 1'b0, 32'h4000, 1'b1, 4'd2, 2'b11, 32'h3000, 32'h3004};
    tbl[16] = '{2'b11, 2'b11, 1'b0, 32'h5000, 1'b1, 4'd2, 2'b11, 32'h5000, 32'h5004};

    // Reset state
    #12;
    chk("reset_cnt", 32'(ibuf_cnt_o), 32'd0);
    chk("reset_vld", 32'(dec_vld_o), 32'd0);
    chk("reset_rdy", 32'(inst_rdy_f2), 32'd1);
    reset = 1'b0;
    step();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].vld, tbl[i].take, tbl[i].flush, tbl[i].pc, '0);
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(inst_rdy_f2), 32'(tbl[i].rdy));
      step();
      chk($sformatf("v%0d_cnt", i), 32'(ibuf_cnt_o), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_dvld", i), 32'(dec_vld_o), 32'(tbl[i].dvld));
      if (tbl[i].dvld[0]) begin
        chk($sformatf("v%0d_pc0", i), dec_pc_o[0], tbl[i].pc0);
        chk($sformatf("v%0d_opc0", i), dec_opc_o[0], opc_of(tbl[i].pc0));
      end
      if (tbl[i].dvld[1]) chk($sformatf("v%0d_pc1", i), dec_pc_o[1], tbl[i].pc1);
    end

    // Wrap-around streaming: 40 sequential instructions with full take
    drive(2'b00, 2'b00, 1'b1, 32'h0, '0);
    step();
    next_in = 0;
    next_out = 0;
    cyc = 0;
    while (next_out < 40 && cyc < 200) begin
      drive((next_in < 40) ? 2'b11 : 2'b00, dec_vld_o, 1'b0, 32'(next_in * 4), '0);
      #1;
      acc = inst_rdy_f2 && (next_in < 40);
      for (int k = 0; k < 2; k++) begin
        if (dec_vld_o[k]) begin
          chk("wrap_pc", dec_pc_o[k], 32'(next_out * 4));
          chk("wrap_opc", dec_opc_o[k], opc_of(32'(next_out * 4)));
          next_out++;
        end
      end
      step();
      if (acc) next_in += 2;
      cyc++;
    end
    chk("wrap_total", 32'(next_out), 32'd40);
    chk("wrap_empty", 32'(ibuf_cnt_o), 32'd0);

    // Fault info travels with its own entries only
    drive(2'b11, 2'b00, 1'b0, 32'h100, '0);
    step();
    drive(2'b11, 2'b00, 1'b0, 32'h108, pf);
    step();
    drive(2'b11, 2'b00, 1'b0, 32'h110, 3'b001);
    step();
    drive(2'b00, 2'b00, 1'b0, 32'h0, '0);
    #1;
    chk("fault_cnt", 32'(ibuf_cnt_o), 32'd6);
    chk("fault_prior0", 32'(dec_info_o[0]), 32'd0);
    chk("fault_prior1", 32'(dec_info_o[1]), 32'd0);
    drive(2'b00, 2'b11, 1'b0, 32'h0, '0);
    step();
    chk("fault_pc", dec_pc_o[0], 32'h108);
    chk("fault_pf0", 32'(dec_info_o[0]), 32'(pf));
    chk("fault_pf1", 32'(dec_info_o[1]), 32'(pf));
    step();
    chk("fault_later0", 32'(dec_info_o[0]), 32'd1);
    chk("fault_later1", 32'(dec_info_o[1]), 32'd1);
    step();
    chk("fault_drain", 32'(ibuf_cnt_o), 32'd0);

    // Flush while full, with a valid packet and a take in the same cycle
    for (int p = 0; p < 4; p++) begin
      drive(2'b11, 2'b00, 1'b0, 32'(32'h500 + 8 * p), '0);
      step();
    end
    drive(2'b00, 2'b00, 1'b0, 32'h0, '0);
    #1;
    chk("full_cnt", 32'(ibuf_cnt_o), 32'd8);
    chk("full_rdy", 32'(inst_rdy_f2), 32'd0);
    drive(2'b11, 2'b11, 1'b1, 32'h700, '0);
    #1;
    chk("flush_rdy_during", 32'(inst_rdy_f2), 32'd0);
    step();
    drive(2'b00, 2'b00, 1'b0, 32'h0, '0);
    #1;
    chk("flush_cnt", 32'(ibuf_cnt_o), 32'd0);
    chk("flush_vld", 32'(dec_vld_o), 32'd0);
    chk("flush_rdy", 32'(inst_rdy_f2), 32'd1);
    drive(2'b11, 2'b00, 1'b0, 32'h600, '0);
    step();
    chk("after_flush_pc0", dec_pc_o[0], 32'h600);
    chk("after_flush_cnt", 32'(ibuf_cnt_o), 32'd2);

    // Asynchronous reset mid-operation clears immediately
    drive(2'b00, 2'b00, 1'b0, 32'h0, '0);
    reset = 1'b1;
    #1;
    chk("areset_cnt", 32'(ibuf_cnt_o), 32'd0);
    chk("areset_vld", 32'(dec_vld_o), 32'd0);
    reset = 1'b0;
    step();
    chk("areset_rdy", 32'(inst_rdy_f2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
